// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: arbitrates ALU and load writeback and runs a zero-clear sweep.
// Optional `WB_ROUND_ROBIN_EN selects round-robin contention; otherwise requester 1 (loads) has fixed priority.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        ctrl_writeEn,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_idx;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_hs0;
  logic        w_hs1;

`ifdef WB_ROUND_ROBIN_EN
  logic r_last1;  // 1 when requester 1 holds the most recent grant

  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || r_last1);
    w_grant1 = req1_valid && (!req0_valid || !r_last1);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset)  r_last1 <= 1'b1;
    else if (w_hs0)  r_last1 <= 1'b0;
    else if (w_hs1)  r_last1 <= 1'b1;
  end
`else
  always_comb begin
    w_grant1 = req1_valid;
    w_grant0 = req0_valid && !req1_valid;
  end
`endif

  assign w_hs0 = req0_valid && req0_ready;
  assign w_hs1 = req1_valid && req1_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (ctrl_reset) r_state <= ARB;
    else            r_state <= w_state_next;
  end

  // NOTE: defaulting every output at the top of always_comb keeps it free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB:     if (clear_start)      w_state_next = CLEAR;
      CLEAR:   if (r_idx == 5'd31)   w_state_next = ARB;
      default:                       w_state_next = ARB;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    clear_busy = 1'b0;
    case (r_state)
      ARB: begin
        req0_ready = !clear_start && w_grant0;
        req1_ready = !clear_start && w_grant1;
      end
      CLEAR:   clear_busy = 1'b1;
      default: clear_busy = 1'b0;
    endcase
  end

  // Registered write port; index/data hold when no write is issued, r0 writes are dropped.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_idx         <= 5'd0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= 5'd0;
      data_writeReg <= 32'd0;
    end else if (r_state == CLEAR) begin
      ctrl_writeEn  <= 1'b1;
      ctrl_writeReg <= r_idx;
      data_writeReg <= 32'd0;
      r_idx         <= r_idx + 5'd1;
    end else begin
      r_idx        <= 5'd1;
      ctrl_writeEn <= 1'b0;
      if (w_hs0 && req0_reg != 5'd0) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= req0_reg;
        data_writeReg <= req0_data;
      end else if (w_hs1 && req1_reg != 5'd0) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= req1_reg;
        data_writeReg <= req1_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clear_start, clear_busy;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_wb_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: sweep flag/index, last grantee, the pending write and the register file contents.
  bit          m_clear;
  int          m_idx;
  int          m_last;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] mrf   [32];
  logic [31:0] tb_rf [32];

  // Requesters hold a request until the model predicts its handshake.
  bit          q0_v, q1_v;
  int          q0_r, q1_r;
  logic [31:0] q0_d, q1_d;

  int obs_g0;
  int obs_busy;

  task automatic cycle(input bit cs, input bit rst);
    bit          e0, e1;
    int          win, hr;
    logic [31:0] hd;
    @(negedge clock);
    if (ctrl_writeEn === 1'b1) tb_rf[ctrl_writeReg] = data_writeReg;
    if (m_we) mrf[m_wreg] = m_wdata;
    req0_valid  = q0_v; req0_reg = 5'(q0_r); req0_data = q0_d;
    req1_valid  = q1_v; req1_reg = 5'(q1_r); req1_data = q1_d;
    clear_start = cs;
    ctrl_reset  = rst;
    if (q0_v && q1_v) begin
`ifdef WB_ROUND_ROBIN_EN
      win = (m_last == 1) ? 0 : 1;
`else
      win = 1;
`endif
    end else begin
      win = q0_v ? 0 : 1;
    end
    e0 = !m_clear && !cs && q0_v && win == 0;
    e1 = !m_clear && !cs && q1_v && win == 1;
    #1;
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("clear_busy", 32'(clear_busy), 32'(m_clear));
    if (req0_ready === 1'b1) obs_g0++;
    if (clear_busy === 1'b1) obs_busy++;
    @(posedge clock);
    hr = e0 ? q0_r : q1_r;
    hd = e0 ? q0_d : q1_d;
    if (e0) q0_v = 1'b0;
    if (e1) q1_v = 1'b0;
    if (rst) begin
      m_clear = 1'b0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_last = 1;
    end else if (m_clear) begin
      m_we = 1'b1; m_wreg = 5'(m_idx); m_wdata = '0;
      if (m_idx == 31) m_clear = 1'b0;
      else             m_idx++;
    end else if (cs) begin
      m_clear = 1'b1; m_idx = 1; m_we = 1'b0;
    end else if (e0 || e1) begin
      m_last = e0 ? 0 : 1;
      m_we   = (hr != 0);
      if (hr != 0) begin
        m_wreg = 5'(hr); m_wdata = hd;
      end
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("ctrl_writeEn",  32'(ctrl_writeEn),  32'(m_we));
    check("ctrl_writeReg", 32'(ctrl_writeReg), 32'(m_wreg));
    check("data_writeReg", data_writeReg,      m_wdata);
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), tb_rf[i], mrf[i]);
  endtask

  task automatic fill_dead();
    for (int i = 1; i < 32; i++) begin
      q0_v = 1'b1; q0_r = i; q0_d = 32'h0000DEAD;
      cycle(1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mrf[i] = '0; tb_rf[i] = '0; end
    q0_v = 0; q1_v = 0; q0_r = 0; q1_r = 0; q0_d = '0; q1_d = '0;
    req0_valid = 0; req1_valid = 0; req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
    clear_start = 0; ctrl_reset = 1;
    m_clear = 0; m_idx = 0; m_last = 1; m_we = 0; m_wreg = '0; m_wdata = '0;
    repeat (2) @(posedge clock);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Lone write from requester 0.
    q0_v = 1; q0_r = 5; q0_d = 32'h0000DEAD;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("r5_after_write", tb_rf[5], 32'h0000DEAD);

    // Four cycles of contention.
    obs_g0 = 0;
    for (int i = 0; i < 4; i++) begin
      q0_v = 1; q0_r = 1; q0_d = 32'h11;
      q1_v = 1; q1_r = 2; q1_d = 32'h22;
      cycle(1'b0, 1'b0);
    end
`ifdef WB_ROUND_ROBIN_EN
    check("contention_grants0", 32'(obs_g0), 32'd2);
`else
    check("contention_grants0", 32'(obs_g0), 32'd0);
`endif
    q0_v = 0; q1_v = 0;
    cycle(1'b0, 1'b0);

    // Write to r0 is accepted and dropped.
    q1_v = 1; q1_r = 0; q1_d = 32'hFFFFFFFF;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("r0_stays_zero", tb_rf[0], 32'h0);

    // Fill with back-to-back writes, then a full sweep with req0 pending.
    fill_dead();
    q0_v = 1; q0_r = 7; q0_d = 32'h1234;
    obs_busy = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) cycle(1'b0, 1'b0);
    check("sweep_busy_cycles", 32'(obs_busy), 32'd31);
    cycle(1'b0, 1'b0);
    compare_rf("after_clear");
    for (int i = 1; i < 32; i++) check($sformatf("cleared_r%0d", i), tb_rf[i], 32'h0);
    cycle(1'b0, 1'b0);
    check("post_sweep_grant_r7", tb_rf[7], 32'h1234);

    // Reset during a sweep.
    fill_dead();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 40 && m_idx != 10; i++) cycle(1'b0, 1'b0);
    check("sweep_reached_idx10", 32'(m_idx), 32'd10);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    compare_rf("after_abort");
    check("r20_survives_abort", tb_rf[20], 32'h0000DEAD);

    // Randomized traffic with occasional sweeps and resets.
    for (int n = 0; n < 600; n++) begin
      if (!q0_v && ($urandom % 3) != 0) begin
        q0_v = 1; q0_r = int'($urandom % 32); q0_d = $urandom;
      end
      if (!q1_v && ($urandom % 3) != 0) begin
        q1_v = 1; q1_r = int'($urandom % 32); q1_d = $urandom;
      end
      cycle(($urandom % 60) == 0, ($urandom % 150) == 0);
    end
    q0_v = 0; q1_v = 0;
    repeat (34) cycle(1'b0, 1'b0);
    compare_rf("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
